pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_sat_cnt.sv | 34 +++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: control-field widths
// and the state encoding of the two-entry (skid) variant.
package pipe_pkg;

    localparam int unsigned WB_W        = 2;
    localparam int unsigned M_W         = 3;
    localparam int unsigned EX_W        = 5;
    // Total control bits carried per beat (WB + M + EX).
    localparam int unsigned PIPE_CTRL_W = WB_W + M_W + EX_W;

    // Occupancy of the two-entry stage: nothing held, main only, main plus skid.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module pipe_sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [Width-1:0] count
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] count_q, count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {Width{1'b1}})) begin
            count_d = count_q + One;
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying control, data words and two
// register specifiers, with a saturating output-stall counter.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry stage (main + skid)
// with a registered in_ready; otherwise a single entry with combinational
// in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = PIPE_CTRL_W,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 4,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0]   in_data,
    input  logic [2*REG_W-1:0]           in_regs,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0]   out_data,
    output logic [2*REG_W-1:0]           out_regs,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int unsigned DataBits = NUM_DATA * DATA_W;
    localparam int unsigned RegBits  = 2 * REG_W;
    localparam int unsigned BeatW    = CTRL_W + DataBits + RegBits;

    logic [BeatW-1:0] in_beat;
    logic [BeatW-1:0] main_q, main_d;
    logic             in_xfer, out_xfer;

    assign in_beat  = {in_ctrl, in_data, in_regs};
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    skid_state_e      state_q, state_d;
    logic [BeatW-1:0] skid_q, skid_d;
    logic             in_ready_q;

    // Occupancy transitions; flush discards everything, including an offered beat.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_d  = in_beat;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_beat;
                    end else if (in_xfer) begin
                        skid_d  = in_beat;
                        state_d = StSkid;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = StFull;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State, skid entry and registered in_ready (low only while skid is occupied).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StSkid);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
`else
    logic valid_q, valid_d;

    // Single entry: refill in the same cycle it drains, so streaming has no bubble.
    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
        end else begin
            if (out_xfer) begin
                valid_d = 1'b0;
            end
            if (in_xfer) begin
                valid_d = 1'b1;
                main_d  = in_beat;
            end
        end
    end

    // Entry valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign in_ready  = out_ready || !valid_q;
    assign out_valid = valid_q;
`endif

    // Main (output) entry; its data and regs persist through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else begin
            main_q <= main_d;
        end
    end

    // Control is masked to zero on a bubble so downstream sees a no-op.
    assign out_ctrl = out_valid ? main_q[BeatW-1 -: CTRL_W] : '0;
    assign out_data = main_q[RegBits +: DataBits];
    assign out_regs = main_q[RegBits-1:0];

    pipe_sat_cnt #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based reference model.
// A second instance with a 4-bit stall counter covers saturation.
module tb_pipe_stage_reg;

    localparam int CTRL_W   = 10;
    localparam int DATA_W   = 32;
    localparam int NUM_DATA = 4;
    localparam int REG_W    = 5;
    localparam int CNT_W    = 16;
`ifdef PIPE_STAGE_SKID_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0]          ctrl;
        logic [NUM_DATA*DATA_W-1:0] data;
        logic [2*REG_W-1:0]         regs;
    } beat_t;

    localparam int AW = 1 + $bits(beat_t) + 1 + CNT_W;
    localparam int BW = 1 + $bits(beat_t) + 1 + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [CTRL_W-1:0]          in_ctrl = '0;
    logic [NUM_DATA*DATA_W-1:0] in_data = '0;
    logic [2*REG_W-1:0]         in_regs = '0;

    logic                       in_ready, out_valid;
    logic [CTRL_W-1:0]          out_ctrl;
    logic [NUM_DATA*DATA_W-1:0] out_data;
    logic [2*REG_W-1:0]         out_regs;
    logic [CNT_W-1:0]           stall_cnt;

    logic                       b_in_ready, b_out_valid;
    logic [CTRL_W-1:0]          b_out_ctrl;
    logic [NUM_DATA*DATA_W-1:0] b_out_data;
    logic [2*REG_W-1:0]         b_out_regs;
    logic [3:0]                 b_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .REG_W(REG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_regs(out_regs), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .REG_W(REG_W), .CNT_W(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .out_regs(b_out_regs), .stall_cnt(b_stall_cnt)
    );

    logic [AW+BW-1:0] obs;
    assign obs = {out_valid, out_ctrl, out_data, out_regs, in_ready, stall_cnt,
                  b_out_valid, b_out_ctrl, b_out_data, b_out_regs, b_in_ready, b_stall_cnt};

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of held beats, last beat shown, stall cycles seen.
    beat_t mq[$];
    beat_t shown;
    int    stall;

    function automatic logic m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return mq.size() < Cap;
`else
        return out_ready || (mq.size() == 0);
`endif
    endfunction

    function automatic logic [AW+BW-1:0] exp_vec();
        logic              v;
        logic              r;
        logic [CTRL_W-1:0] c;
        logic [15:0]       s16;
        logic [3:0]        s4;
        v   = mq.size() != 0;
        r   = m_in_ready();
        c   = v ? shown.ctrl : '0;
        s16 = (stall > 65535) ? 16'hFFFF : 16'(stall);
        s4  = (stall > 15) ? 4'hF : 4'(stall);
        return {v, c, shown.data, shown.regs, r, s16, v, c, shown.data, shown.regs, r, s4};
    endfunction

    task automatic model_reset();
        mq.delete();
        shown = '0;
        stall = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic  rdy, v;
        beat_t b;
        rdy = m_in_ready();
        v   = mq.size() != 0;
        if (v && !out_ready) stall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (v && out_ready) b = mq.pop_front();
            if (in_valid && rdy) mq.push_back(beat_t'{in_ctrl, in_data, in_regs});
        end
        if (mq.size() != 0) shown = mq[0];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.ctrl = CTRL_W'($urandom);
        b.data = {$urandom, $urandom, $urandom, $urandom};
        b.regs = (2*REG_W)'($urandom);
        return b;
    endfunction

    task automatic drive(input logic v, input beat_t b, input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = b.ctrl;
        in_data   = b.data;
        in_regs   = b.regs;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        beat_t b;
        b      = rand_beat();
        b.ctrl = 10'h2A5;
        b.data = {96'h0, 32'h0000_1234};
        drive(1'b1, b, 1'b1, 1'b0);
        #1;
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 10'h2A5 || out_data[31:0] !== 32'h0000_1234) begin
            errors++;
            $display("FAIL directed: valid %b ctrl %h w0 %h want 1 2a5 00001234",
                     out_valid, out_ctrl, out_data[31:0]);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL directed_full: got %h want %h", obs, exp_vec());
        end
        tick();
    endtask

    task automatic test_stream();
        beat_t sent[8];
        beat_t got[$];
        int    idx = 0;
        int    base;
        logic  acc;
        base = stall;
        foreach (sent[i]) sent[i] = rand_beat();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx >= 8 && mq.size() == 0) break;
            drive(idx < 8, sent[(idx < 8) ? idx : 0], !(cyc inside {3, 4, 5}), 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stream cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            if (out_valid && out_ready) got.push_back(beat_t'{out_ctrl, out_data, out_regs});
            acc = (idx < 8) && m_in_ready();
            tick();
            if (acc) idx++;
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL stream_count: got %0d beats want 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++;
                $display("FAIL stream_order %0d: got %h want %h", i, got[i], sent[i]);
            end
        end
        checks++;
        if (stall_cnt !== 16'(base + 3)) begin
            errors++;
            $display("FAIL stream_stall: got %0d want %0d", stall_cnt, base + 3);
        end
    endtask

    task automatic test_skid();
        beat_t sent[4];
        beat_t got[$];
        int    idx = 0;
        logic  acc;
        foreach (sent[i]) sent[i] = rand_beat();
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive(1'b1, sent[idx], 1'b0, 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL skid_fill cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            acc = m_in_ready();
            tick();
            if (acc) idx++;
`ifdef PIPE_STAGE_SKID_EN
            if (acc && idx == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL skid_in_ready: got %b want 0", in_ready);
                end
            end
`endif
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL skid_drain cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            if (out_valid) got.push_back(beat_t'{out_ctrl, out_data, out_regs});
            tick();
        end
        checks++;
        if (got.size() != Cap) begin
            errors++;
            $display("FAIL skid_count: got %0d want %0d", got.size(), Cap);
        end
        for (int i = 0; i < got.size() && i < Cap; i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++;
                $display("FAIL skid_order %0d: got %h want %h", i, got[i], sent[i]);
            end
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        tick();
        drive(1'b1, rand_beat(), 1'b0, 1'b1);
        #1;
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL flush_bubble: valid %b ctrl %h want 0 0", out_valid, out_ctrl);
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            checks++;
            if (obs !== exp_vec() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_after cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        drain();
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 22; cyc++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL saturate cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            tick();
        end
        checks++;
        if (b_stall_cnt !== 4'hF) begin
            errors++;
            $display("FAIL saturate_final: got %0d want 15", b_stall_cnt);
        end
        drain();
    endtask

    task automatic test_random();
        beat_t b;
        logic  acc;
        b = rand_beat();
        for (int cyc = 0; cyc < 300; cyc++) begin
            drive(($urandom % 4) != 0, b, ($urandom % 3) != 0, ($urandom % 23) == 0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            acc = in_valid && m_in_ready() && !flush;
            tick();
            if (acc) b = rand_beat();
        end
        drain();
    endtask

    task automatic test_async_reset();
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        tick();
        drive(1'b1, rand_beat(), 1'b0, 1'b0);
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec() || out_data !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs, exp_vec());
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            checks++;
            if (obs !== exp_vec() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL async_after cyc %0d: got %h want %h", cyc, obs, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_stream();
        test_skid();
        test_flush();
        test_saturate();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
